div_ctrl: RTL and testbench

Front-end controller for the iterative long-division unit in the execute stage. Sits between the EX-stage M-extension decode and the divider: it resolves RISC-V special cases (divide-by-zero, signed overflow) in zero extra cycles, keeps a one-entry result cache so a stalled or replayed instruction is never re-divided, and sequences one request per miss into the divider. It owns the `stall` seen by the pipeline for DIV/DIVU/REM/REMU.

---
 rtl/div_pkg.sv | 6 +
 rtl/div_ctrl_if.sv | 25 ++
 rtl/div_special_case.sv | 17 +
 rtl/div_ctrl.sv | 61 ++++++
 tb/tb_div_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: opcode and FSM state encodings plus the most-negative-integer pattern for the divide front end
package div_pkg;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_e;
  typedef enum logic {IDLE, BUSY} div_state_e;
  localparam logic [31:0] DIV_MIN_INT = 32'h8000_0000;
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: pipeline-side req/flush/opcode/a/b/o/stall and divider-side div_* signals; slave = controller, master = pipeline plus divider
interface div_ctrl_if #(parameter int DATA_WIDTH = 32);
  logic                  req;
  logic                  flush;
  logic [1:0]            opcode;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] o;
  logic                  stall;
  logic                  div_req;
  logic                  div_flush;
  logic [1:0]            div_opcode;
  logic [DATA_WIDTH-1:0] div_a;
  logic [DATA_WIDTH-1:0] div_b;
  logic [DATA_WIDTH-1:0] div_o;
  logic                  div_stall;
  modport slave (
    input  req, flush, opcode, a, b, div_o, div_stall,
    output o, stall, div_req, div_flush, div_opcode, div_a, div_b
  );
  modport master (
    output req, flush, opcode, a, b, div_o, div_stall,
    input  o, stall, div_req, div_flush, div_opcode, div_a, div_b
  );
endinterface

// File: rtl/div_special_case.sv
// div_special_case: flags divide-by-zero and signed overflow (in opcode/a/b, out is_special/special_result), zero wins over overflow
module div_special_case import div_pkg::*; #(parameter int DATA_WIDTH = 32) (
  input  logic [1:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  is_special,
  output logic [DATA_WIDTH-1:0] special_result
);
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {DIV_MIN_INT[31], {(DATA_WIDTH-1){1'b0}}};
  logic zero, ovf;
  always_comb begin
    zero = b == '0;
    ovf = !opcode[0] && a == MIN_INT && &b;
    is_special = zero || ovf;
    special_result = zero ? (opcode[1] ? a : '1) : ovf ? (opcode[1] ? '0 : a) : '0;
  end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: divider front end with special cases and a one-entry result cache (clk, async rst, bus = div_ctrl_if.slave)
module div_ctrl import div_pkg::*; #(parameter int DATA_WIDTH = 32) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);
  div_state_e state, state_nxt;
  logic [1:0] pend_op, key_op;
  logic [DATA_WIDTH-1:0] pend_a, pend_b, key_a, key_b, cache_data, special_result;
  logic cache_valid, is_special, active, hit, issue, done;
  div_special_case #(.DATA_WIDTH(DATA_WIDTH)) u_special (
    .opcode(bus.opcode),
    .a(bus.a),
    .b(bus.b),
    .is_special(is_special),
    .special_result(special_result)
  );
  always_comb begin
    active = state == IDLE && bus.req && !bus.flush && !rst;
    hit = cache_valid && {key_op, key_a, key_b} == {bus.opcode, bus.a, bus.b};
    issue = active && !is_special && !hit;
    done = state == BUSY && !bus.flush && !bus.div_stall;
    state_nxt = issue ? BUSY : (state == BUSY && (bus.flush || !bus.div_stall)) ? IDLE : state;
  end
  assign bus.o = (active && is_special) ? special_result :
                 (active && hit) ? cache_data :
                 done ? bus.div_o : '0;
  assign bus.stall = issue || (state == BUSY && !bus.flush && bus.div_stall);
  assign bus.div_req = issue;
  assign bus.div_flush = bus.flush;
  assign bus.div_opcode = bus.opcode;
  assign bus.div_a = bus.a;
  assign bus.div_b = bus.b;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_op <= '0;
      pend_a <= '0;
      pend_b <= '0;
      key_op <= '0;
      key_a <= '0;
      key_b <= '0;
      cache_data <= '0;
      cache_valid <= 1'b0;
    end else begin
      if (issue) begin
        pend_op <= bus.opcode;
        pend_a <= bus.a;
        pend_b <= bus.b;
      end
      if (done) begin
        key_op <= pend_op;
        key_a <= pend_a;
        key_b <= pend_b;
        cache_data <= bus.div_o;
        cache_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a 32-cycle behavioural divider
module tb_div_ctrl;
  import div_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_q[$];
  div_ctrl_if #(.DATA_WIDTH(32)) bus ();
  div_ctrl #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  int cnt;
  logic [31:0] q;
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (op == 2'b00) return sx / sy;
    if (op == 2'b01) return x / y;
    if (op == 2'b10) return sx % sy;
    return x % y;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 0;
      q <= '0;
    end else if (bus.div_flush) cnt <= 0;
    else if (bus.div_req) begin
      cnt <= 32;
      q <= model(bus.div_opcode, bus.div_a, bus.div_b);
    end else if (cnt != 0) cnt <= cnt - 1;
  assign bus.div_stall = cnt != 0;
  assign bus.div_o = q;

  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (prev_req && bus.div_req) begin
      errs++;
      $display("FAIL div_req_consecutive got 1 want 0 at %0t", $time);
    end
    prev_req <= bus.div_req;
  end

  task automatic put(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.opcode = op;
    bus.a = x;
    bus.b = y;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic run_miss(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    int k = 0;
    int reqs = 0;
    logic [31:0] ex;
    put(op, x, y);
    exp_q.push_back(e);
    @(negedge clk);
    vecs++;
    if (bus.div_req !== 1'b1 || bus.stall !== 1'b1) begin
      errs++;
      $display("FAIL miss_issue a=%h b=%h div_req=%b stall=%b want 1 1", x, y, bus.div_req, bus.stall);
    end
    do begin
      @(negedge clk);
      k++;
      reqs += int'(bus.div_req);
    end while (bus.stall === 1'b1 && k < 100);
    vecs++;
    if (k != 33) begin
      errs++;
      $display("FAIL miss_latency a=%h b=%h got %0d want 33", x, y, k);
    end
    vecs++;
    if (reqs != 0) begin
      errs++;
      $display("FAIL busy_div_req got %0d want 0", reqs);
    end
    ex = exp_q.pop_front();
    vecs++;
    if (bus.o !== ex) begin
      errs++;
      $display("FAIL miss_result a=%h b=%h got %h want %h", x, y, bus.o, ex);
    end
  endtask

  task automatic test_reset();
    bus.req = 1'b1;
    bus.opcode = DIVU;
    bus.a = 32'd100;
    bus.b = 32'd7;
    repeat (2) @(negedge clk);
    vecs++;
    if ({bus.stall, bus.div_req, bus.o} !== 34'h0 || dut.cache_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs stall=%b div_req=%b o=%h cache_valid=%b want 0 0 0 0", bus.stall, bus.div_req, bus.o, dut.cache_valid);
    end
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if ({bus.stall, bus.div_req, bus.o} !== 34'h0) begin
      errs++;
      $display("FAIL post_reset_outputs stall=%b div_req=%b o=%h want 0 0 0", bus.stall, bus.div_req, bus.o);
    end
  endtask

  task automatic test_special();
    logic [1:0] ops[7] = '{DIV, REM, DIVU, REMU, DIV, REM, DIV};
    logic [31:0] xs[7] = '{32'd7, 32'd7, 32'd5, 32'd9, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys[7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] es[7] = '{32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ex;
    for (int i = 0; i < 7; i++) begin
      put(ops[i], xs[i], ys[i]);
      exp_q.push_back(es[i]);
      @(negedge clk);
      ex = exp_q.pop_front();
      vecs++;
      if (bus.o !== ex || bus.stall !== 1'b0 || bus.div_req !== 1'b0) begin
        errs++;
        $display("FAIL special_%0d o=%h stall=%b div_req=%b want %h 0 0", i, bus.o, bus.stall, bus.div_req, ex);
      end
    end
    idle();
  endtask

  task automatic test_miss_hit();
    logic [31:0] ex;
    run_miss(DIVU, 32'd100, 32'd7, 32'd14);
    put(DIVU, 32'd100, 32'd7);
    exp_q.push_back(32'd14);
    @(negedge clk);
    ex = exp_q.pop_front();
    vecs++;
    if (bus.o !== ex || bus.stall !== 1'b0 || bus.div_req !== 1'b0) begin
      errs++;
      $display("FAIL held_hit o=%h stall=%b div_req=%b want %h 0 0", bus.o, bus.stall, bus.div_req, ex);
    end
    idle();
  endtask

  task automatic test_rem_neg();
    run_miss(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
    idle();
  endtask

  task automatic test_back_to_back();
    run_miss(DIV, 32'd50, 32'hFFFF_FFFB, 32'hFFFF_FFF6);
    run_miss(DIVU, 32'd1000, 32'd3, 32'd333);
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] ex;
    put(DIV, 32'd1000, 32'hFFFF_FFF9);
    @(negedge clk);
    vecs++;
    if (bus.div_req !== 1'b1) begin
      errs++;
      $display("FAIL flush_issue div_req=%b want 1", bus.div_req);
    end
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(negedge clk);
    vecs++;
    if (bus.div_flush !== 1'b1 || bus.stall !== 1'b0 || bus.o !== 32'h0) begin
      errs++;
      $display("FAIL flush_busy div_flush=%b stall=%b o=%h want 1 0 0", bus.div_flush, bus.stall, bus.o);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    vecs++;
    if (bus.stall !== 1'b0 || bus.div_flush !== 1'b0) begin
      errs++;
      $display("FAIL after_flush stall=%b div_flush=%b want 0 0", bus.stall, bus.div_flush);
    end
    put(DIVU, 32'd1000, 32'd3);
    exp_q.push_back(32'd333);
    @(negedge clk);
    ex = exp_q.pop_front();
    vecs++;
    if (bus.o !== ex || bus.stall !== 1'b0 || bus.div_req !== 1'b0) begin
      errs++;
      $display("FAIL cache_kept o=%h stall=%b div_req=%b want %h 0 0", bus.o, bus.stall, bus.div_req, ex);
    end
    run_miss(DIV, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72);
    put(REMU, 32'd1000, 32'd7);
    bus.flush = 1'b1;
    @(negedge clk);
    vecs++;
    if (bus.div_req !== 1'b0 || bus.stall !== 1'b0 || bus.o !== 32'h0 || bus.div_flush !== 1'b1) begin
      errs++;
      $display("FAIL flush_idle div_req=%b stall=%b o=%h div_flush=%b want 0 0 0 1", bus.div_req, bus.stall, bus.o, bus.div_flush);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.req = 1'b0;
  endtask

  task automatic test_async_reset();
    put(REMU, 32'd12345, 32'd10);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (bus.stall !== 1'b0 || bus.div_req !== 1'b0 || dut.cache_valid !== 1'b0) begin
      errs++;
      $display("FAIL async_reset stall=%b div_req=%b cache_valid=%b want 0 0 0", bus.stall, bus.div_req, dut.cache_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 1'b0;
    run_miss(DIV, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72);
    idle();
  endtask

  initial begin
    bus.req = 1'b0;
    bus.flush = 1'b0;
    bus.opcode = 2'b00;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_special();
    test_miss_hit();
    test_rem_neg();
    test_back_to_back();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
